// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command accumulator and serializer.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        TERM1 = 2'd2,
        TERM2 = 2'd3
    } cmd_state_e;

    localparam logic [7:0] CMD_TERM_BLE  = 8'h0D;
    localparam logic [7:0] CMD_TERM_HI   = 8'hBE;
    localparam logic [7:0] CMD_TERM_LO   = 8'hEF;
    localparam int         CMD_MAX_BYTES = 128;

endpackage

// File: rtl/uart_cmd_timeout_counter.sv
// Counts consecutive stalled cycles; timeout fires on the stall that reaches TIMEOUT.
module uart_cmd_timeout_counter #(
    parameter int TIMEOUT = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic clear,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        timeout = stall && (cnt_q == CW'(TIMEOUT - 1));
        cnt_d   = cnt_q;
        if (clear || timeout) begin
            cnt_d = '0;
        end else if (stall) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_command_serializer.sv
// Streams a latched command buffer plus link terminator over a valid/ready byte port.
// Optional stall abort is enabled with `define UART_CMD_SERIALIZER_TIMEOUT_EN.
module uart_command_serializer
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 2000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1023:0] input_data,
    input  logic [7:0]    input_data_size,
    input  logic          start,
    input  logic          ble_side,
    input  logic          tx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    output logic          busy,
    output logic          done,
    output logic          error
);

    cmd_state_e     state_q, state_d;
    logic [1023:0]  payload_q, payload_d;
    logic [7:0]     size_q, size_d;
    logic [7:0]     idx_q, idx_d;
    logic           ble_q, ble_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           transfer;
    logic           timeout;

    assign transfer = tx_valid_q && tx_ready;

`ifdef UART_CMD_SERIALIZER_TIMEOUT_EN
    uart_cmd_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .stall   (tx_valid_q && !tx_ready),
        .clear   (transfer),
        .timeout (timeout)
    );
`else
    // Without the stall counter the block waits forever; TIMEOUT has no effect.
    assign timeout = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        size_d     = size_q;
        idx_d      = idx_q;
        ble_d      = ble_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (input_data_size == 8'd0 || int'(input_data_size) > CMD_MAX_BYTES) begin
                        error_d = 1'b1;
                    end else begin
                        payload_d  = input_data;
                        size_d     = input_data_size;
                        ble_d      = ble_side;
                        idx_d      = 8'd0;
                        tx_data_d  = input_data[7:0];
                        tx_valid_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = SEND;
                    end
                end
            end
            SEND: begin
                if (transfer) begin
                    if (idx_q == size_q - 8'd1) begin
                        tx_data_d = ble_q ? CMD_TERM_BLE : CMD_TERM_HI;
                        state_d   = TERM1;
                    end else begin
                        // Next byte is preloaded so the output stays back-to-back.
                        idx_d     = idx_q + 8'd1;
                        tx_data_d = payload_q[{idx_d, 3'b000} +: 8];
                    end
                end
            end
            TERM1: begin
                if (transfer) begin
                    if (ble_q) begin
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        tx_data_d = CMD_TERM_LO;
                        state_d   = TERM2;
                    end
                end
            end
            TERM2: begin
                if (transfer) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 8'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
        payload_q <= payload_d;
        size_q    <= size_d;
        ble_q     <= ble_d;
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
